// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply issue/collect stage: op encodings,
// FSM states, per-op context and the raw-op decoder.
package mdu_pkg;

    localparam int MDU_XLEN = 64;
    localparam int MDU_OPW  = 3;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_MULW   = 3'd4
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } mdu_state_e;

    // What must survive from accept to product capture.
    typedef struct packed {
        mdu_op_e op;
        logic    neg;
    } mdu_ctx_t;

    // Reserved encodings 5-7 behave as MUL.
    function automatic mdu_op_e mdu_decode(input logic [2:0] raw);
        return (raw > 3'd4) ? MDU_MUL : mdu_op_e'(raw);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Applies the deferred sign to the unsigned 2*XLEN product and picks the
// architectural result (low, high, or sign-extended low word).
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic            neg,
    input  mdu_op_e         op,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] fixed;

    always_comb begin
        prod  = {hi, lo};
        fixed = neg ? -prod : prod;
        case (op)
            MDU_MUL:  result = fixed[XLEN-1:0];
            MDU_MULW: result = {{(XLEN-32){fixed[31]}}, fixed[31:0]};
            default:  result = fixed[2*XLEN-1:XLEN];
        endcase
    end

endmodule

// File: rtl/mdu_issue.sv
// Control stage between EX and the iterative multiplier: strips operand signs,
// issues magnitudes, collects and corrects the product, returns one result.
// Optional: define MDU_ZERO_BYPASS_EN to answer zero-operand ops without the multiplier.
module mdu_issue
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN,
    parameter int OPW  = MDU_OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OPW-1:0]  req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy,
    output logic            m_valid,
    output logic            m_flush,
    input  logic            m_ready,
    output logic [XLEN-1:0] m_a,
    output logic [XLEN-1:0] m_b,
    input  logic            m_out_valid,
    input  logic [XLEN-1:0] m_res_hi,
    input  logic [XLEN-1:0] m_res_lo
);

    mdu_state_e      state, state_nxt;
    mdu_ctx_t        ctx_q;
    mdu_op_e         op_in;
    logic            accept;
    logic            capture;
    logic            sa, sb;
    logic            zero_in;
    logic [XLEN-1:0] fix_result;

    assign op_in  = mdu_decode(3'(req_op));
    assign accept = req_valid & req_ready & ~flush;

    // MUL/MULW low bits do not depend on signedness, so only the high ops strip signs.
    assign sa = ((op_in == MDU_MULH) | (op_in == MDU_MULHSU)) & req_a[XLEN-1];
    assign sb = (op_in == MDU_MULH) & req_b[XLEN-1];

`ifdef MDU_ZERO_BYPASS_EN
    assign zero_in = (req_a == '0) | (req_b == '0);
`else
    assign zero_in = 1'b0;
`endif

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP) & ~flush;

    always_comb begin
        state_nxt = state;
        m_valid   = 1'b0;
        m_flush   = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = zero_in ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                // Nothing has reached the multiplier yet, so a flush here needs no abort.
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (m_ready) begin
                    m_valid   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    m_flush   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (m_out_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .hi     (m_res_hi),
        .lo     (m_res_lo),
        .neg    (ctx_q.neg),
        .op     (ctx_q.op),
        .result (fix_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ctx_q    <= '0;
            m_a      <= '0;
            m_b      <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ctx_q.op  <= op_in;
                ctx_q.neg <= sa ^ sb;
                m_a       <= sa ? -req_a : req_a;
                m_b       <= sb ? -req_b : req_b;
                if (zero_in) rsp_data <= '0;
            end
            if (capture) rsp_data <= fix_result;
        end
    end

endmodule

// File: tb/tb_mdu_issue.sv
// Scoreboard bench for mdu_issue: a behavioural multiplier checks issued
// magnitudes, a response monitor checks results popped from an expect queue.
module tb_mdu_issue;

    localparam int MUL_LAT = 4;
`ifdef MDU_ZERO_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
                           OP_MULHU = 3'd3, OP_MULW = 3'd4;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        req_valid = 1'b0, rsp_ready = 1'b1;
    logic        m_ready = 1'b0, m_out_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [63:0] req_a = '0, req_b = '0, m_res_hi = '0, m_res_lo = '0;
    logic        req_ready, rsp_valid, busy, m_valid, m_flush;
    logic [63:0] rsp_data, m_a, m_b;

    int           total = 0, bad = 0;
    logic         mr_en = 1'b1;
    int           mul_cnt = 0;
    logic [127:0] prod = '0;
    logic [127:0] iss_e;
    logic [63:0]  rsp_e;
    logic [127:0] exp_iss[$];
    logic [63:0]  exp_rsp[$];

    mdu_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .m_valid(m_valid), .m_flush(m_flush), .m_ready(m_ready),
        .m_a(m_a), .m_b(m_b), .m_out_valid(m_out_valid),
        .m_res_hi(m_res_hi), .m_res_lo(m_res_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Multiplier model: handshake and countdown on negedge, m_ready updated mid-high-phase.
    always @(negedge clk) begin
        m_out_valid = 1'b0;
        if (rst) begin
            mul_cnt = 0;
        end else begin
            if (m_flush) begin
                mul_cnt = 0;
            end else if (mul_cnt != 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    m_out_valid = 1'b1;
                    {m_res_hi, m_res_lo} = prod;
                end
            end
            if (m_valid && m_ready) begin
                if (exp_iss.size() == 0) begin
                    total++; bad++;
                    $display("FAIL issue_unexpected: got m_valid with m_a=%h m_b=%h want no issue", m_a, m_b);
                end else begin
                    iss_e = exp_iss.pop_front();
                    chk("issue_m_a", m_a, iss_e[127:64]);
                    chk("issue_m_b", m_b, iss_e[63:0]);
                end
                prod    = {64'd0, m_a} * {64'd0, m_b};
                mul_cnt = MUL_LAT;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        m_ready = mr_en && (mul_cnt == 0) && !rst;
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: got rsp_data=%h want no response", rsp_data);
            end else begin
                rsp_e = exp_rsp.pop_front();
                chk("rsp_data", rsp_data, rsp_e);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: got req_ready=0 want 1");
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 200) begin @(posedge clk); #1; n++; end
        if (busy) begin
            total++; bad++;
            $display("FAIL %s_timeout: got busy=1 want 0", nm);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] ma, input logic [63:0] mb,
                          input logic [63:0] res);
        exp_iss.push_back({ma, mb});
        exp_rsp.push_back(res);
        send(op, a, b);
        wait_idle(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_flush", 64'(m_flush), 64'd0);
        chk("rst_m_a", m_a, 64'd0);
        chk("rst_m_b", m_b, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        run_op("mul_7_m3", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulh_m2_3", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
               64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulhu_m2_3", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd2);
        run_op("mulw_wrap", OP_MULW, 64'h8000_0000, 64'd2, 64'h8000_0000, 64'd2, 64'd0);
        run_op("mulw_sext", OP_MULW, 64'h4000_0000, 64'd2,
               64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000);
        run_op("mulh_min_min", OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
        run_op("op7_as_mul", 3'd7, 64'd5, 64'd6, 64'd5, 64'd6, 64'd30);

        // Back-pressure on both sides: multiplier not ready, then EX not consuming.
        mr_en = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        exp_iss.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
        exp_rsp.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        send(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_m_valid", 64'(m_valid), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        mr_en = 1'b1;
        begin
            int n = 0;
            while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
            chk("bp_rsp_arrive", 64'(rsp_valid), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle("bp");

        // Flush while waiting on the multiplier.
        exp_iss.push_back({64'd5, 64'd7});
        send(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFB, 64'd7);
        begin
            int n = 0;
            while (exp_iss.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fl_m_flush_on", 64'(m_flush), 64'd1);
        chk("fl_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_m_flush_off", 64'(m_flush), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                seen = seen | rsp_valid;
            end
            chk("fl_no_rsp", 64'(seen), 64'd0);
        end
        @(posedge clk); #1;
        run_op("mulhsu_after_flush", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req_valid = 1'b1; req_op = OP_MUL; req_a = 64'd3; req_b = 64'd4;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", 64'(busy), 64'd0);
        chk("idle_flush_ready", 64'(req_ready), 64'd1);

        // Zero operand: bypass answers straight away, otherwise full multiplier path.
        if (!BYPASS) exp_iss.push_back({64'd0, 64'd5});
        exp_rsp.push_back(64'd0);
        send(OP_MUL, 64'd0, 64'd5);
        @(negedge clk);
        chk("zero_rsp_early", 64'(rsp_valid), 64'(BYPASS));
        wait_idle("zero");

        repeat (4) @(posedge clk);
        #1;
        chk("iss_q_empty", 64'(exp_iss.size()), 64'd0);
        chk("rsp_q_empty", 64'(exp_rsp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
